// File: rtl/muldiv_unit.sv
// Radix-2 serial MULT/MULTU/DIV/DIVU engine feeding the HI/LO register file.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; divides stay serial.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic               div_q,   div_d;
  logic               s1_q,    s1_d;
  logic               s2_q,    s2_d;
  logic [WIDTH-1:0]   b_q,     b_d;
  logic [2*WIDTH-1:0] acc_q,   acc_d;
  logic [2*WIDTH-1:0] res_q,   res_d;
  logic [2*WIDTH-1:0] com_q,   com_d;

  logic               neg1, neg2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     rsh;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] step_acc;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod;
`endif

  // Magnitude result -> signed result; divide-by-zero forces an all-ones quotient.
  function automatic logic [2*WIDTH-1:0] fixup(input logic is_div, input logic n1,
                                               input logic n2, input logic bz,
                                               input logic [2*WIDTH-1:0] r);
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] rm;
    if (!is_div) begin
      return (n1 ^ n2) ? -r : r;
    end
    q  = r[WIDTH-1:0];
    rm = r[2*WIDTH-1:WIDTH];
    if (n1 ^ n2) q = -q;
    if (n1)      rm = -rm;
    if (bz)      q = '1;
    return {rm, q};
  endfunction

  always_comb begin
    neg1 = ~op[0] & src1[WIDTH-1];
    neg2 = ~op[0] & src2[WIDTH-1];
    mag1 = neg1 ? -src1 : src1;
    mag2 = neg2 ? -src2 : src2;

    msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rsh  = acc_q[2*WIDTH-1:WIDTH-1];
    diff = {1'b0, rsh} - {2'b0, b_q};
    if (div_q) begin
      step_acc = diff[WIDTH+1] ? {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step_acc = {msum, acc_q[WIDTH-1:1]};
    end
`ifdef MULDIV_FAST_MUL_EN
    prod = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
`endif

    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    com_d   = com_q;

    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          div_d   = op[1];
          s1_d    = neg1;
          s2_d    = neg2;
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_CALC;
          // mul: multiplier shifts out of acc low half; div: dividend shifts into remainder
          b_d     = op[1] ? mag2 : mag1;
          acc_d   = op[1] ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
`ifdef MULDIV_FAST_MUL_EN
          if (!op[1]) begin
            res_d   = fixup(1'b0, neg1, neg2, 1'b0, prod);
            state_d = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc;
          if (cnt_q == '0) begin
            res_d   = fixup(div_q, s1_q, s2_q, b_q == '0, step_acc);
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!cancel) com_d = res_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      com_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      com_q   <= com_d;
    end
  end

  // A cancelled DONE shows the last committed result, never the abandoned one.
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE) && !cancel;
  assign we   = done;
  assign hi_o = done ? res_q[2*WIDTH-1:WIDTH] : com_q[2*WIDTH-1:WIDTH];
  assign lo_o = done ? res_q[WIDTH-1:0]       : com_q[WIDTH-1:0];

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cancel = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [W-1:0]  src1 = '0;
  logic [W-1:0]  src2 = '0;
  logic          busy, done, we;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int exp_we = 0;
  logic [W-1:0] c_hi = '0;
  logic [W-1:0] c_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .start(start), .op(op),
    .src1(src1), .src2(src2), .cancel(cancel), .busy(busy), .done(done),
    .we(we), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (we) we_cnt <= we_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Plain-arithmetic reference: returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic signed [63:0] sa, sb, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      2'd0: return sa * sb;
      2'd1: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == '0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int lat(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
    if (!o[1]) return 1;
`endif
    return W + 1;
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit cancel_done);
    logic [63:0] e;
    int n;
    e = model(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk); #1;
    n = 1;
    chk("busy_run", busy, 1);
    while (!we && n < W + 8) begin
      start = 1'($urandom_range(0, 1));
      op = 2'($urandom);
      src1 = $urandom;
      src2 = $urandom;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("latency", n, lat(o));
    chk("done", done, 1);
    chk("hi", hi, e[63:32]);
    chk("lo", lo, e[31:0]);
    if (cancel_done) begin
      cancel = 1'b1;
      #1;
      chk("we_cancel", we, 0);
      chk("hi_cancel", hi, c_hi);
      chk("lo_cancel", lo, c_lo);
    end else begin
      c_hi = e[63:32];
      c_lo = e[31:0];
      exp_we++;
    end
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("idle", busy, 0);
    chk("hi_hold", hi, c_hi);
    chk("lo_hold", lo, c_lo);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_we", {done, we}, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk) rst_n = 1'b1;

    do_op(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    do_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    do_op(2'd3, 32'd7, 32'd2, 1'b0);
    do_op(2'd3, 32'h1234_5678, 32'h0, 1'b0);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(2'd2, 32'hFFFF_FFF9, 32'h0, 1'b0);
    do_op(2'd1, 32'd3, 32'd5, 1'b0);

    // cancel in cycle 10 of a divide, re-launch in cycle 11
    @(negedge clk);
    start = 1'b1; op = 2'd3; src1 = 32'd1000; src2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_idle", busy, 0);
    chk("cancel_hi", hi, c_hi);
    chk("cancel_lo", lo, c_lo);
    do_op(2'd3, 32'd1000, 32'd7, 1'b0);

    // start together with cancel launches nothing
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'd1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    chk("start_cancel", busy, 0);

    do_op(2'd2, 32'd100, 32'hFFFF_FFF6, 1'b1);
    do_op(2'd1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);

    // asynchronous reset in cycle 20 of an operation
    @(negedge clk);
    start = 1'b1; op = 2'd2; src1 = 32'hFFFF_0000; src2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_we", we, 0);
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    c_hi = '0;
    c_lo = '0;
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      do_op(2'($urandom), pick(), pick(), 1'b0);
    end

    @(posedge clk); #1;
    chk("we_count", we_cnt, exp_we);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
